// File: rtl/seg_pipe_cla_adder.sv
// Pipelined wide adder/subtractor: one SEG-bit segment resolved per stage,
// carry registered between stages, 4-bit CLA slices inside each segment.
module seg_pipe_cla_adder #(
  parameter int WIDTH = 128,
  parameter int SEG   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int STAGES = WIDTH / SEG;
  localparam int SLICES = SEG / 4;

  // Slice-level group generate/propagate; slices ripple through c.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] s;
    logic [3:0]     p, g, x;
    logic [3:0]     cc;
    logic           gg, pg, c;
    s = '0;
    c = cin;
    for (int i = 0; i < SLICES; i++) begin
      p = a[4*i +: 4] | b[4*i +: 4];
      g = a[4*i +: 4] & b[4*i +: 4];
      x = a[4*i +: 4] ^ b[4*i +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg = &p;
      s[4*i +: 4] = x ^ cc;
      c = gg | (pg & c);
    end
    return {c, s};
  endfunction

  logic                   en;
  logic [WIDTH-1:0]       a_p [STAGES];
  logic [WIDTH-1:0]       b_p [STAGES];
  logic [WIDTH-1:0]       s_p [STAGES];
  logic [STAGES-1:0]      c_p;
  logic [STAGES-1:0]      vld_p;

  logic [WIDTH-1:0]       a_d [STAGES];
  logic [WIDTH-1:0]       b_d [STAGES];
  logic [WIDTH-1:0]       s_d [STAGES];
  logic [STAGES-1:0]      c_d;
  logic [STAGES-1:0]      v_d;
  logic [WIDTH-1:0]       s_n [STAGES];
  logic [STAGES-1:0]      c_n;

  assign en       = ~vld_p[STAGES-1] | out_ready;
  assign in_ready = en;

  // Stage inputs: stage 0 from the ports, stage k from stage k-1 registers.
  always_comb begin
    a_d[0] = in_a;
    b_d[0] = in_sub ? ~in_b : in_b;
    s_d[0] = '0;
    c_d[0] = in_cin ^ in_sub;
    v_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_p[k-1];
      b_d[k] = b_p[k-1];
      s_d[k] = s_p[k-1];
      c_d[k] = c_p[k-1];
      v_d[k] = vld_p[k-1];
    end
  end

  always_comb begin
    logic [SEG:0] seg;
    seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg    = cla_seg(a_d[k][k*SEG +: SEG], b_d[k][k*SEG +: SEG], c_d[k]);
      s_n[k] = s_d[k];
      s_n[k][k*SEG +: SEG] = seg[SEG-1:0];
      c_n[k] = seg[SEG];
    end
  end

  // Stage registers; data only loads with a valid slot so the output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      c_p   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
        s_p[k] <= '0;
      end
    end else if (en) begin
      vld_p <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_p[k] <= a_d[k];
          b_p[k] <= b_d[k];
          s_p[k] <= s_n[k];
          c_p[k] <= c_n[k];
        end
      end
    end
  end

  logic unused_skew;
  assign unused_skew = ^{a_p[STAGES-1], b_p[STAGES-1]};

  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = s_p[STAGES-1];
  assign out_cout  = c_p[STAGES-1];

endmodule

// File: tb/tb_seg_pipe_cla_adder.sv
// Bench for seg_pipe_cla_adder: 128/32 directed tests plus 64/64 and 16/4 sweeps,
// with a scoreboard queue per instance.
module tb_seg_pipe_cla_adder;

  typedef struct {
    logic [128:0] r;
    int           t;
    bit           lat;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  bit lat_en = 1'b1;

  ent_t qm[$];
  ent_t qx[$];
  ent_t qy[$];

  // Main instance 128/32
  logic         m_in_valid = 0, m_in_ready, m_in_cin = 0, m_in_sub = 0;
  logic [127:0] m_in_a = '0, m_in_b = '0, m_out_sum;
  logic         m_out_valid, m_out_ready = 1, m_out_cout;
  // Sweep instances 64/64 and 16/4
  logic         x_in_valid = 0, x_in_ready, x_in_cin = 0, x_in_sub = 0;
  logic [63:0]  x_in_a = '0, x_in_b = '0, x_out_sum;
  logic         x_out_valid, x_out_ready = 1, x_out_cout;
  logic         y_in_valid = 0, y_in_ready, y_in_cin = 0, y_in_sub = 0;
  logic [15:0]  y_in_a = '0, y_in_b = '0, y_out_sum;
  logic         y_out_valid, y_out_ready = 1, y_out_cout;

  seg_pipe_cla_adder #(.WIDTH(128), .SEG(32)) dut_m (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .in_cin(m_in_cin), .in_sub(m_in_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_sum(m_out_sum), .out_cout(m_out_cout));

  seg_pipe_cla_adder #(.WIDTH(64), .SEG(64)) dut_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .in_a(x_in_a), .in_b(x_in_b), .in_cin(x_in_cin), .in_sub(x_in_sub),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .out_sum(x_out_sum), .out_cout(x_out_cout));

  seg_pipe_cla_adder #(.WIDTH(16), .SEG(4)) dut_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .in_a(y_in_a), .in_b(y_in_b), .in_cin(y_in_cin), .in_sub(y_in_sub),
    .out_valid(y_out_valid), .out_ready(y_out_ready), .out_sum(y_out_sum), .out_cout(y_out_cout));

  // Reference: {cout,sum} at w+1 bits, zero-extended to 129 bits.
  function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic cin, input logic sub, input int w);
    logic [128:0] m, bb, s;
    m  = (129'd1 << w) - 129'd1;
    bb = sub ? ~{1'b0, b} : {1'b0, b};
    s  = ({1'b0, a} & m) + (bb & m) + 129'(cin ^ sub);
    return s & ((m << 1) | 129'd1);
  endfunction

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      qm.delete(); qx.delete(); qy.delete();
    end else begin
      if (m_out_valid && m_out_ready) begin
        chk("m_expected_output", 129'(qm.size() != 0), 129'd1);
        if (qm.size() != 0) begin
          e = qm.pop_front();
          chk("m_result", {m_out_cout, m_out_sum}, e.r);
          if (e.lat) chk("m_latency", 129'(cyc), 129'(e.t));
        end
      end
      if (m_in_valid && m_in_ready)
        qm.push_back('{r: model(m_in_a, m_in_b, m_in_cin, m_in_sub, 128), t: cyc + 4, lat: lat_en});
      if (x_out_valid && x_out_ready) begin
        chk("x_expected_output", 129'(qx.size() != 0), 129'd1);
        if (qx.size() != 0) begin
          e = qx.pop_front();
          chk("x_result", 129'({x_out_cout, x_out_sum}), e.r);
          if (e.lat) chk("x_latency", 129'(cyc), 129'(e.t));
        end
      end
      if (x_in_valid && x_in_ready)
        qx.push_back('{r: model(128'(x_in_a), 128'(x_in_b), x_in_cin, x_in_sub, 64), t: cyc + 1, lat: lat_en});
      if (y_out_valid && y_out_ready) begin
        chk("y_expected_output", 129'(qy.size() != 0), 129'd1);
        if (qy.size() != 0) begin
          e = qy.pop_front();
          chk("y_result", 129'({y_out_cout, y_out_sum}), e.r);
          if (e.lat) chk("y_latency", 129'(cyc), 129'(e.t));
        end
      end
      if (y_in_valid && y_in_ready)
        qy.push_back('{r: model(128'(y_in_a), 128'(y_in_b), y_in_cin, y_in_sub, 16), t: cyc + 4, lat: lat_en});
    end
  end

  task automatic op_m(input logic [127:0] a, input logic [127:0] b, input logic cin, input logic sub);
    bit acc;
    int n;
    m_in_a = a; m_in_b = b; m_in_cin = cin; m_in_sub = sub; m_in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      acc = m_in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("m_accept", 129'(acc), 129'd1);
    m_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qm.size() + qx.size() + qy.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain", 129'(qm.size() + qx.size() + qy.size()), 129'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] held;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 129'(m_out_valid), 129'd0);
    chk("rst_out_sum", 129'(m_out_sum), 129'd0);
    chk("rst_out_cout", 129'(m_out_cout), 129'd0);
    chk("rst_in_ready", 129'(m_in_ready), 129'd1);
    @(posedge clk); #1;

    // Carry across all four stages, then subtraction cases
    op_m({128{1'b1}}, 128'd1, 1'b0, 1'b0);
    drain();
    op_m(128'd5, 128'd7, 1'b0, 1'b1);
    op_m(128'd7, 128'd5, 1'b1, 1'b1);
    op_m({128{1'b1}}, {128{1'b1}}, 1'b1, 1'b0);
    op_m(128'd0, 128'd0, 1'b1, 1'b1);
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 16; i++) op_m(rnd128(), rnd128(), 1'($urandom), 1'($urandom));
    drain();

    // Backpressure mid-stream
    lat_en = 1'b0;
    for (int i = 0; i < 5; i++) op_m(rnd128(), rnd128(), 1'($urandom), 1'($urandom));
    m_out_ready = 1'b0;
    m_in_valid  = 1'b1;
    held = m_out_sum;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 129'(m_in_ready), 129'd0);
      chk("stall_out_valid", 129'(m_out_valid), 129'd1);
      chk("stall_out_sum", 129'(m_out_sum), 129'(held));
      @(posedge clk); #1;
    end
    m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) op_m(rnd128(), rnd128(), 1'($urandom), 1'($urandom));
    drain();
    lat_en = 1'b1;

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) op_m(rnd128(), rnd128(), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 129'(m_out_valid), 129'd0);
    chk("midrst_out_sum", 129'(m_out_sum), 129'd0);
    @(posedge clk); #1;
    op_m(128'h1234_5678_9abc_def0_ffff_ffff_ffff_ffff, 128'd1, 1'b0, 1'b0);
    drain();

    // Config sweeps: exact latency first, then random backpressure
    for (int i = 0; i < 10000; i++) begin
      x_in_valid = ($urandom % 4) != 0;
      y_in_valid = ($urandom % 4) != 0;
      x_in_a = ($urandom % 8 == 0) ? {64{1'b1}} : {$urandom(), $urandom()};
      x_in_b = {$urandom(), $urandom()};
      y_in_a = ($urandom % 8 == 0) ? 16'hffff : 16'($urandom);
      y_in_b = 16'($urandom);
      x_in_cin = 1'($urandom); x_in_sub = 1'($urandom);
      y_in_cin = 1'($urandom); y_in_sub = 1'($urandom);
      if (i == 2000) begin
        x_in_valid = 1'b0;
        y_in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 lat_en = 1'b0;
      end
      if (i >= 2000) begin
        x_out_ready = ($urandom % 3) != 0;
        y_out_ready = ($urandom % 3) != 0;
      end
      @(posedge clk); #1;
    end
    x_in_valid = 1'b0;
    y_in_valid = 1'b0;
    x_out_ready = 1'b1;
    y_out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_pipe_cla_adder.md
Name: seg_pipe_cla_adder

Overview:
- Pipelined, parametrised wide adder/subtractor for the IDDMM datapath.
- Splits WIDTH-bit operands into SEG-bit segments and resolves one segment per pipeline stage, registering the carry between stages.
- Inside each segment, the carry chain is built from 4-bit carry-lookahead slices in group-generate/propagate form.
- Accepts one operation per cycle, with a valid/ready handshake on both sides and backpressure.

Parameters:
- WIDTH, 128, operand and result width in bits; must be a multiple of SEG.
- SEG, 32, bits resolved per pipeline stage; must be a multiple of 4.
- STAGES, WIDTH/SEG, derived (localparam), number of pipeline stages and the latency in cycles.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry-out (add) / no-borrow flag (sub).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits cleared; out_valid=0, out_sum=0, out_cout=0.
  - Stored carries and operand/result skew registers cleared.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; nothing partial appears at the output.
- Arithmetic:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_cin XOR in_sub.
  - {out_cout, out_sum} = in_a + b_eff + c0, computed at WIDTH+1 bits.
  - Sub with in_cin=0 gives a-b; sub with in_cin=1 gives a-b-1.
  - In sub mode, out_cout=1 means no borrow (a >= b + in_cin).
- Pipeline advance: en = ~out_valid | out_ready; in_ready = en, combinational.
  - A transfer occurs when in_valid & in_ready.
  - When en=0, every stage holds its state, including valid bits, carries and partial results.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and b_eff using the carry registered by stage k-1; stage 0 uses c0.
  - Writes sum bits [k*SEG +: SEG] into the result skew register and registers its carry for stage k+1.
  - The higher segments of A/b_eff travel in skew registers alongside.
- Segment internals:
  - SEG/4 4-bit CLA slices; per slice p=a|b, g=a&b, with full lookahead inside the slice.
  - Ripple between slices within a segment is permitted.
  - No combinational path crosses a stage boundary.
- Latency and throughput:
  - An accepted input appears on out_sum/out_cout exactly STAGES cycles later when there is no backpressure.
  - Throughput is 1 operation per cycle.
- Output: out_valid = valid bit of the last stage.
  - out_sum/out_cout stay stable while out_valid=1 and out_ready=0.
- Bubbles: in_valid=0 with en=1 inserts an invalid slot.
  - Invalid slots never assert out_valid.
  - Data in invalid slots is don't-care, but the output registers update only on valid results.
- Simultaneous events:
  - Acceptance of a new input and output handshake in the same cycle proceed together with no loss; this is the full-throughput case.
  - rst has priority over all handshakes.
- Ordering: results leave strictly in input order; no reordering, no drop, no duplication.
- Wrap-around: the sum wraps modulo 2^WIDTH; overflow is reported only via out_cout. There is no signed-overflow flag.
- Degenerate config: SEG=WIDTH gives a single stage (STAGES=1) with latency 1.

Test Plan:
- WIDTH=128, SEG=32, add: A=2^128-1, B=1, cin=0 -> out_sum=0, out_cout=1, out_valid exactly 4 cycles after acceptance; carry propagates across all 4 stages.
- Sub: A=5, B=7, cin=0 -> out_sum=2^128-2, out_cout=0. A=7, B=5, cin=1 -> out_sum=1, out_cout=1.
- Back-to-back stream: 16 random add/sub operations, in_valid held high, out_ready=1 -> 16 results on 16 consecutive cycles, starting cycle 4, each matching the 129-bit reference model.
- Backpressure: stream 8 operations, drop out_ready for 3 cycles mid-stream.
  - in_ready=0 during the stall; out_sum stays stable while stalled.
  - All 8 results arrive in order with none lost or duplicated.
- Reset mid-operation: accept 3 operations, assert rst for 1 cycle at cycle 2.
  - out_valid=0 and out_sum=0 the cycle after reset; none of the 3 results ever appear.
  - A new operation accepted after reset completes in 4 cycles with the correct result.
- Config sweep: SEG=WIDTH=64 and SEG=4, WIDTH=16 -> latency 1 and 4 respectively, 10k random vectors all matching the reference model.
